// File: rtl/shift_register_param.sv
// Parameterised shift/rotate register with immediate single-step operation
// and a multi-step mode that repeats a latched shift/rotate a given number of times.
module shift_register_param #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       control,
    input  logic             msb,
    input  logic             lsb_in,
    input  logic [WIDTH-1:0] parallel_load,
    input  logic [CNT_W-1:0] amount,
    input  logic             start,
    output logic [WIDTH-1:0] parallel_read,
    output logic             lsb,
    output logic             msb_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_SHR   = 3'b000,
        OP_SHL   = 3'b001,
        OP_LOAD  = 3'b010,
        OP_HOLD0 = 3'b011,
        OP_ROR   = 3'b100,
        OP_ROL   = 3'b101,
        OP_ASR   = 3'b110,
        OP_HOLD1 = 3'b111
    } op_t;

    state_t           r_state, w_state_nxt;
    op_t              r_op, w_op_nxt, w_step_op;
    logic [WIDTH-1:0] r_data, w_data_nxt, w_step;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_multi_code;

    // In RUN the latched operation drives the datapath; otherwise the live control does.
    assign w_step_op = (r_state == S_RUN) ? r_op : op_t'(control);

    always_comb begin
        w_step = r_data;
        case (w_step_op)
            OP_SHR:  w_step = {msb, r_data[WIDTH-1:1]};
            OP_SHL:  w_step = {r_data[WIDTH-2:0], lsb_in};
            OP_LOAD: w_step = parallel_load;
            OP_ROR:  w_step = {r_data[0], r_data[WIDTH-1:1]};
            OP_ROL:  w_step = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
            OP_ASR:  w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            default: w_step = r_data;
        endcase
    end

    always_comb begin
        w_multi_code = 1'b0;
        case (op_t'(control))
            OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: w_multi_code = 1'b1;
            default:                                w_multi_code = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        case (r_state)
            S_IDLE: begin
                if (start && w_multi_code) begin
                    w_op_nxt    = op_t'(control);
                    w_cnt_nxt   = amount;
                    w_state_nxt = (amount == '0) ? S_DONE : S_RUN;
                end else begin
                    w_data_nxt = w_step;
                end
            end
            S_RUN: begin
                w_data_nxt = w_step;
                // Count stops at 1: that step is the last one.
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_SHR;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
        end
    end

    assign parallel_read = r_data;
    assign lsb           = r_data[0];
    assign msb_out       = r_data[WIDTH-1];
    assign busy          = (r_state == S_RUN);
    assign done          = (r_state == S_DONE);

endmodule
